// File: rtl/dcm_reset_sequencer_if.sv
// DCM reset sequencer signal bundle: LOCKED inputs, DCM/system reset outputs
// and status. Optional DCM STATUS inputs appear when DCMSEQ_STATUS_MON_EN is
// defined.
interface dcm_reset_sequencer_if;
  logic       cpu_locked;
  logic       video_locked;
`ifdef DCMSEQ_STATUS_MON_EN
  logic [2:0] cpu_status;
  logic [2:0] video_status;
`endif
  logic       dcm_cpu_rst;
  logic       dcm_video_rst;
  logic       sys_rst;
  logic       clocks_ok;
  logic       fault;
  logic [3:0] retry_cnt;

  // Sequencer side
  modport master (
    input  cpu_locked,
    input  video_locked,
`ifdef DCMSEQ_STATUS_MON_EN
    input  cpu_status,
    input  video_status,
`endif
    output dcm_cpu_rst,
    output dcm_video_rst,
    output sys_rst,
    output clocks_ok,
    output fault,
    output retry_cnt
  );

  // Clock generator / system side
  modport slave (
    output cpu_locked,
    output video_locked,
`ifdef DCMSEQ_STATUS_MON_EN
    output cpu_status,
    output video_status,
`endif
    input  dcm_cpu_rst,
    input  dcm_video_rst,
    input  sys_rst,
    input  clocks_ok,
    input  fault,
    input  retry_cnt
  );
endinterface

// File: rtl/dcm_reset_sequencer.sv
// DCM reset sequencer: pulses both DCM RST pins, waits for LOCKED, retries
// failed locks, holds sys_rst until both DCMs are locked and settled.
// Optional feature macro: DCMSEQ_STATUS_MON_EN (adds DCM STATUS[2] monitoring
// in SETTLE and RUN, treated like lock loss).
module dcm_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT     = 50000,
  parameter int unsigned SETTLE_CYCLES    = 1024,
  parameter int unsigned MAX_RETRIES      = 7
) (
  input logic                   CLK,
  input logic                   RST,
  dcm_reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_PULSE,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [15:0] PULSE_LAST  = 16'(RST_PULSE_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  // SETTLE occupies SETTLE_CYCLES+1 cycles so that release lands exactly
  // 2+SETTLE_CYCLES+1 cycles after the raw locks are first sampled high.
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  logic [1:0]  sync_c;
  logic [1:0]  sync_v;
  logic        lk_c;
  logic        lk_v;
  logic        locks_ok;
  logic        clk_good;

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic [3:0]  retry;
  logic [3:0]  retry_n;
  logic        fail;

  logic        dcm_rst_q;
  logic        sys_rst_q;
  logic        clocks_ok_q;
  logic        fault_q;
  logic        dcm_rst_n;
  logic        sys_rst_n;
  logic        clocks_ok_n;
  logic        fault_n;

  // Two-flop synchronisers for the asynchronous LOCKED inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_c <= '0;
      sync_v <= '0;
    end else begin
      sync_c <= {sync_c[0], bus.cpu_locked};
      sync_v <= {sync_v[0], bus.video_locked};
    end
  end

  assign lk_c     = sync_c[1];
  assign lk_v     = sync_v[1];
  assign locks_ok = lk_c & lk_v;

`ifdef DCMSEQ_STATUS_MON_EN
  logic [1:0] sync_cs;
  logic [1:0] sync_vs;

  // Two-flop synchronisers for STATUS[2] (CLKFX stopped); STATUS[1] unused
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_cs <= '0;
      sync_vs <= '0;
    end else begin
      sync_cs <= {sync_cs[0], bus.cpu_status[2]};
      sync_vs <= {sync_vs[0], bus.video_status[2]};
    end
  end

  assign clk_good = locks_ok & ~sync_cs[1] & ~sync_vs[1];
`else
  assign clk_good = locks_ok;
`endif

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_PULSE;
      cnt         <= '0;
      retry       <= '0;
      dcm_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      clocks_ok_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry       <= retry_n;
      dcm_rst_q   <= dcm_rst_n;
      sys_rst_q   <= sys_rst_n;
      clocks_ok_q <= clocks_ok_n;
      fault_q     <= fault_n;
    end
  end

  // Next-state, cycle counter and retry bookkeeping
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry;
    fail    = 1'b0;
    unique case (state)
      S_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_WAIT_LOCK: begin
        if (locks_ok) begin
          state_n = S_SETTLE;
          cnt_n   = '0;
        end else if (cnt == LOCK_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_SETTLE: begin
        if (!clk_good) begin
          fail = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
          retry_n = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_RUN: begin
        if (!clk_good) begin
          state_n = S_PULSE;
          cnt_n   = '0;
        end
      end
      S_FAULT: begin
        state_n = S_FAULT;
      end
      default: begin
        state_n = S_FAULT;
      end
    endcase

    if (fail) begin
      cnt_n = '0;
      if (retry != RETRY_MAX) begin
        retry_n = retry + 4'd1;
      end
      state_n = (retry + 4'd1 >= RETRY_MAX) ? S_FAULT : S_PULSE;
    end
  end

  // Output decode from the upcoming state so outputs register in step with it
  always_comb begin
    dcm_rst_n   = 1'b1;
    sys_rst_n   = 1'b1;
    clocks_ok_n = 1'b0;
    fault_n     = 1'b0;
    unique case (state_n)
      S_PULSE: begin
        dcm_rst_n = 1'b1;
      end
      S_WAIT_LOCK, S_SETTLE: begin
        dcm_rst_n = 1'b0;
      end
      S_RUN: begin
        dcm_rst_n   = 1'b0;
        sys_rst_n   = 1'b0;
        clocks_ok_n = 1'b1;
      end
      S_FAULT: begin
        fault_n = 1'b1;
      end
      default: begin
        fault_n = 1'b1;
      end
    endcase
  end

  assign bus.dcm_cpu_rst   = dcm_rst_q;
  assign bus.dcm_video_rst = dcm_rst_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.clocks_ok     = clocks_ok_q;
  assign bus.fault         = fault_q;
  assign bus.retry_cnt     = retry;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Bench for dcm_reset_sequencer: directed scenarios with literal cycle
// expectations plus randomized lock behaviour, all checked every cycle
// against a phase/age reference model.
module tb_dcm_reset_sequencer;

  localparam int P_PULSE   = 4;
  localparam int P_TIMEOUT = 100;
  localparam int P_SETTLE  = 8;
  localparam int P_RETRIES = 3;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcm_reset_sequencer_if bus();

  dcm_reset_sequencer #(
    .RST_PULSE_CYCLES(P_PULSE),
    .LOCK_TIMEOUT(P_TIMEOUT),
    .SETTLE_CYCLES(P_SETTLE),
    .MAX_RETRIES(P_RETRIES)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int t     = 0;

  // Reference model: current phase, cycles spent in it, failed attempts,
  // and the two-cycle view delay of each raw lock.
  int     ph      = PH_PULSE;
  int     age     = 0;
  int     m_retry = 0;
  bit [1:0] dc    = '0;
  bit [1:0] dv    = '0;
  bit     model_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled
  task automatic model_edge();
    bit ok;
    bit failed;
    if (rst) begin
      ph = PH_PULSE; age = 0; m_retry = 0; dc = '0; dv = '0;
      return;
    end
    ok     = dc[1] & dv[1];
    failed = 1'b0;
    dc = {dc[0], bus.cpu_locked};
    dv = {dv[0], bus.video_locked};
    case (ph)
      PH_PULSE: begin
        age++;
        if (age == P_PULSE) begin ph = PH_WAIT; age = 0; end
      end
      PH_WAIT: begin
        if (ok) begin
          ph = PH_SETTLE; age = 0;
        end else begin
          age++;
          if (age == P_TIMEOUT) failed = 1'b1;
        end
      end
      PH_SETTLE: begin
        if (!ok) begin
          failed = 1'b1;
        end else begin
          age++;
          if (age == P_SETTLE + 1) begin ph = PH_RUN; age = 0; m_retry = 0; end
        end
      end
      PH_RUN: begin
        if (!ok) begin ph = PH_PULSE; age = 0; end
      end
      default: ;
    endcase
    if (failed) begin
      m_retry++;
      age = 0;
      ph  = (m_retry >= P_RETRIES) ? PH_FAULT : PH_PULSE;
    end
  endtask

  task automatic model_check();
    int dcm_exp;
    dcm_exp = (ph == PH_PULSE || ph == PH_FAULT) ? 1 : 0;
    chk("model_dcm_cpu_rst",   int'(bus.dcm_cpu_rst),   dcm_exp);
    chk("model_dcm_video_rst", int'(bus.dcm_video_rst), dcm_exp);
    chk("model_sys_rst",       int'(bus.sys_rst),   (ph != PH_RUN)   ? 1 : 0);
    chk("model_clocks_ok",     int'(bus.clocks_ok), (ph == PH_RUN)   ? 1 : 0);
    chk("model_fault",         int'(bus.fault),     (ph == PH_FAULT) ? 1 : 0);
    chk("model_retry_cnt",     int'(bus.retry_cnt), m_retry);
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    t++;
    if (model_valid) model_check();
  endtask

  // Reset edge becomes cycle 0
  task automatic do_reset();
    rst = 1'b1;
    model_valid = 1'b1;
    tick();
    rst = 1'b0;
    t = 0;
  endtask

  initial begin
    bus.cpu_locked   = 1'b0;
    bus.video_locked = 1'b0;
`ifdef DCMSEQ_STATUS_MON_EN
    bus.cpu_status   = '0;
    bus.video_status = '0;
`endif

    // Locks rise at cycle 20: DCM reset cycles 0-3, release at cycle 31
    do_reset();
    chk("s1_dcm_rst_t0", int'(bus.dcm_cpu_rst), 1);
    chk("s1_sys_rst_t0", int'(bus.sys_rst), 1);
    repeat (3) tick();
    chk("s1_dcm_rst_t3", int'(bus.dcm_cpu_rst), 1);
    tick();
    chk("s1_dcm_rst_t4", int'(bus.dcm_cpu_rst), 0);
    chk("s1_dcm_video_rst_t4", int'(bus.dcm_video_rst), 0);
    repeat (15) tick();
    bus.cpu_locked   = 1'b1;
    bus.video_locked = 1'b1;
    repeat (11) tick();
    chk("s1_sys_rst_t30", int'(bus.sys_rst), 1);
    tick();
    chk("s1_sys_rst_t31", int'(bus.sys_rst), 0);
    chk("s1_clocks_ok_t31", int'(bus.clocks_ok), 1);

    // One-cycle video lock drop in RUN at cycle 35
    repeat (4) tick();
    bus.video_locked = 1'b0;
    tick();
    bus.video_locked = 1'b1;
    tick();
    chk("s3_sys_rst_t37", int'(bus.sys_rst), 0);
    tick();
    chk("s3_sys_rst_t38", int'(bus.sys_rst), 1);
    chk("s3_clocks_ok_t38", int'(bus.clocks_ok), 0);
    chk("s3_dcm_rst_t38", int'(bus.dcm_cpu_rst), 1);
    chk("s3_retry_t38", int'(bus.retry_cnt), 0);
    repeat (3) tick();
    chk("s3_dcm_rst_t41", int'(bus.dcm_cpu_rst), 1);
    tick();
    chk("s3_dcm_rst_t42", int'(bus.dcm_cpu_rst), 0);
    repeat (10) tick();
    chk("s3_sys_rst_t52", int'(bus.sys_rst), 0);

    // cpu lock glitch at cycle 8 while settling (SETTLE spans 5..13)
    do_reset();
    repeat (8) tick();
    bus.cpu_locked = 1'b0;
    tick();
    bus.cpu_locked = 1'b1;
    tick();
    chk("s4_retry_t10", int'(bus.retry_cnt), 0);
    tick();
    chk("s4_retry_t11", int'(bus.retry_cnt), 1);
    chk("s4_dcm_rst_t11", int'(bus.dcm_cpu_rst), 1);
    for (int unsigned i = 0; i < 13; i++) begin
      tick();
      chk("s4_sys_rst_held", int'(bus.sys_rst), 1);
    end
    tick();
    chk("s4_sys_rst_t25", int'(bus.sys_rst), 0);
    chk("s4_retry_t25", int'(bus.retry_cnt), 0);

    // RST while settling, then restart to RUN at cycle 14
    do_reset();
    repeat (7) tick();
    chk("s5_dcm_rst_settle", int'(bus.dcm_cpu_rst), 0);
    do_reset();
    chk("s5_dcm_rst_after_rst", int'(bus.dcm_cpu_rst), 1);
    chk("s5_sys_rst_after_rst", int'(bus.sys_rst), 1);
    chk("s5_clocks_ok_after_rst", int'(bus.clocks_ok), 0);
    repeat (13) tick();
    chk("s5_sys_rst_t13", int'(bus.sys_rst), 1);
    tick();
    chk("s5_sys_rst_t14", int'(bus.sys_rst), 0);

    // Locks never rise: retries at 104, 208, 312 and fault at 312
    bus.cpu_locked   = 1'b0;
    bus.video_locked = 1'b0;
    do_reset();
    for (int unsigned i = 0; i < 315; i++) begin
      tick();
      case (t)
        103: chk("s2_retry_t103", int'(bus.retry_cnt), 0);
        104: chk("s2_retry_t104", int'(bus.retry_cnt), 1);
        207: chk("s2_retry_t207", int'(bus.retry_cnt), 1);
        208: chk("s2_retry_t208", int'(bus.retry_cnt), 2);
        311: chk("s2_fault_t311", int'(bus.fault), 0);
        312: begin
          chk("s2_fault_t312", int'(bus.fault), 1);
          chk("s2_retry_t312", int'(bus.retry_cnt), 3);
          chk("s2_dcm_rst_t312", int'(bus.dcm_cpu_rst), 1);
        end
        315: chk("s2_dcm_rst_t315", int'(bus.dcm_video_rst), 1);
        default: ;
      endcase
    end

    // RST in FAULT clears everything and restarts the sequence
    do_reset();
    chk("s5_fault_cleared", int'(bus.fault), 0);
    chk("s5_retry_cleared", int'(bus.retry_cnt), 0);
    chk("s5_dcm_rst_fault_rst", int'(bus.dcm_cpu_rst), 1);
    repeat (4) tick();
    chk("s5_dcm_rst_restart_t4", int'(bus.dcm_cpu_rst), 0);

    // Randomized lock activity with occasional RST
    for (int unsigned i = 0; i < 4000; i++) begin
      if (bus.cpu_locked) begin
        if ($urandom_range(0, 59) == 0) bus.cpu_locked = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.cpu_locked = 1'b1;
      end
      if (bus.video_locked) begin
        if ($urandom_range(0, 59) == 0) bus.video_locked = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.video_locked = 1'b1;
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
